timer_cfg_arbiter: RTL and testbench

Sequences configuration writes into the hour/minute timer and shares its single CPU-style write port between two requesters (port 0: CPU, port 1: time-sync agent). Each accepted request is range-checked, then turned into two write strobes, minute first and then hour, on the timer's `w_n`/`w_en_n`/`t`/`addr` port. The block sits between the requesters and the timer, and is the only driver of that port.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_wr_strobe.sv | 72 +++++++
 rtl/timer_cfg_arbiter.sv | 128 ++++++++++++
 tb/tb_timer_cfg_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the hour/minute timer and its configuration write arbiter.
package timer_pkg;

  localparam int          CLK_FREQ    = 10_000_000;
  localparam logic [7:0]  MAX_HOUR    = 8'd23;
  localparam logic [7:0]  MAX_MINUTE  = 8'd59;
  localparam logic [15:0] ADDR_MINUTE = 16'h0000;
  localparam logic [15:0] ADDR_HOUR   = 16'h0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MIN_LO,
    ST_MIN_HI,
    ST_HR_LO,
    ST_HR_HI,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_LO,
    PH_HI
  } strobe_phase_t;

  function automatic logic time_valid(input logic [7:0] hour, input logic [7:0] minute);
    return (hour <= MAX_HOUR) && (minute <= MAX_MINUTE);
  endfunction

endpackage

// File: rtl/timer_wr_strobe.sv
// One timer write: w_n low for PULSE_LEN cycles, then high for HOLD cycles with t/addr held.
module timer_wr_strobe
  import timer_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int HOLD      = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  data,
  input  logic [15:0] addr_in,
  output logic        w_n,
  output logic [7:0]  t,
  output logic [15:0] addr,
  output logic        lo_end,
  output logic        done
);

  localparam logic [15:0] LO_LAST = 16'(PULSE_LEN - 1);
  localparam logic [15:0] HI_LAST = 16'(HOLD - 1);

  strobe_phase_t r_phase, w_phase_next;
  logic [15:0]   r_cnt, w_cnt_next;
  logic [7:0]    r_t;
  logic [15:0]   r_addr;

  assign lo_end = (r_phase == PH_LO) && (r_cnt == LO_LAST);
  assign done   = (r_phase == PH_HI) && (r_cnt == HI_LAST);
  assign w_n    = (r_phase != PH_LO);
  assign t      = r_t;
  assign addr   = r_addr;

  // A start in the last HI cycle chains straight into the next LO phase.
  always_comb begin
    w_phase_next = r_phase;
    w_cnt_next   = r_cnt + 16'd1;
    if (start) begin
      w_phase_next = PH_LO;
      w_cnt_next   = '0;
    end else begin
      case (r_phase)
        PH_LO: if (lo_end) begin
          w_phase_next = PH_HI;
          w_cnt_next   = '0;
        end
        PH_HI: if (done) begin
          w_phase_next = PH_IDLE;
          w_cnt_next   = '0;
        end
        default: w_cnt_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_t     <= '0;
      r_addr  <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_cnt   <= w_cnt_next;
      if (start) begin
        r_t    <= data;
        r_addr <= addr_in;
      end
    end
  end

endmodule

// File: rtl/timer_cfg_arbiter.sv
// Round-robin arbiter for two timer-configuration requesters; issues minute then hour writes.
module timer_cfg_arbiter
  import timer_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int HOLD      = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [7:0]  req_hour0,
  input  logic [7:0]  req_hour1,
  input  logic [7:0]  req_min0,
  input  logic [7:0]  req_min1,
  output logic [1:0]  ack,
  output logic        err,
  output logic        busy,
  output logic        w_n,
  output logic        w_en_n,
  output logic [7:0]  t,
  output logic [15:0] addr
);

  arb_state_t  r_state, w_state_next;
  logic        r_prio;
  logic        r_grant;
  logic        r_err;
  logic [7:0]  r_hour;

  logic        w_grant;
  logic [7:0]  w_sel_hour, w_sel_min;
  logic        w_valid;
  logic        w_accept;
  logic        w_start;
  logic [7:0]  w_start_data;
  logic [15:0] w_start_addr;
  logic        w_lo_end, w_done;

  assign w_grant    = req[r_prio] ? r_prio : ~r_prio;
  assign w_sel_hour = w_grant ? req_hour1 : req_hour0;
  assign w_sel_min  = w_grant ? req_min1  : req_min0;
  assign w_valid    = time_valid(w_sel_hour, w_sel_min);
  assign w_accept   = (r_state == ST_IDLE) && (|req);

  timer_wr_strobe #(
    .PULSE_LEN (PULSE_LEN),
    .HOLD      (HOLD)
  ) u_strobe (
    .clock   (clock),
    .rst_n   (rst_n),
    .start   (w_start),
    .data    (w_start_data),
    .addr_in (w_start_addr),
    .w_n     (w_n),
    .t       (t),
    .addr    (addr),
    .lo_end  (w_lo_end),
    .done    (w_done)
  );

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_start_data = r_hour;
    w_start_addr = ADDR_HOUR;
    ack          = 2'b00;
    err          = 1'b0;
    busy         = (r_state != ST_IDLE);
    w_en_n       = 1'b1;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (w_valid) begin
          w_start      = 1'b1;
          w_start_data = w_sel_min;
          w_start_addr = ADDR_MINUTE;
          w_state_next = ST_MIN_LO;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_MIN_LO: begin
        w_en_n = 1'b0;
        if (w_lo_end) w_state_next = ST_MIN_HI;
      end
      ST_MIN_HI: begin
        w_en_n = 1'b0;
        if (w_done) begin
          w_start      = 1'b1;
          w_state_next = ST_HR_LO;
        end
      end
      ST_HR_LO: begin
        w_en_n = 1'b0;
        if (w_lo_end) w_state_next = ST_HR_HI;
      end
      ST_HR_HI: begin
        w_en_n = 1'b0;
        if (w_done) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        ack[r_grant] = 1'b1;
        err          = r_err;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
      r_grant <= 1'b0;
      r_err   <= 1'b0;
      r_hour  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // Pointer moves to the port just passed over so it wins the next tie.
        r_prio  <= ~w_grant;
        r_grant <= w_grant;
        r_err   <= ~w_valid;
        r_hour  <= w_sel_hour;
      end
    end
  end

endmodule

// File: tb/tb_timer_cfg_arbiter.sv
// Directed bench for timer_cfg_arbiter with a small timer write model on the default instance.
module tb_timer_cfg_arbiter;

  logic        clock;
  logic        rst_n;
  logic [1:0]  req, req2;
  logic [7:0]  req_hour0, req_hour1, req_min0, req_min1;
  logic [1:0]  ack, ack2;
  logic        err, err2, busy, busy2;
  logic        w_n, w_n2, w_en_n, w_en_n2;
  logic [7:0]  t, t2;
  logic [15:0] addr, addr2;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] tm_hour, tm_min;
  logic       tm_wn_d;
  logic       preset_en, tick_en;
  logic [7:0] preset_hour, preset_min;

  timer_cfg_arbiter dut (
    .clock(clock), .rst_n(rst_n), .req(req),
    .req_hour0(req_hour0), .req_hour1(req_hour1),
    .req_min0(req_min0), .req_min1(req_min1),
    .ack(ack), .err(err), .busy(busy), .w_n(w_n), .w_en_n(w_en_n),
    .t(t), .addr(addr)
  );

  timer_cfg_arbiter #(.PULSE_LEN(1), .HOLD(3)) dut2 (
    .clock(clock), .rst_n(rst_n), .req(req2),
    .req_hour0(req_hour0), .req_hour1(req_hour1),
    .req_min0(req_min0), .req_min1(req_min1),
    .ack(ack2), .err(err2), .busy(busy2), .w_n(w_n2), .w_en_n(w_en_n2),
    .t(t2), .addr(addr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Timer model: sees the w_n rise one clock late and latches t into the addressed register.
  always @(posedge clock) begin
    if (!rst_n) begin
      tm_hour <= 8'd0;
      tm_min  <= 8'd0;
      tm_wn_d <= 1'b1;
    end else begin
      tm_wn_d <= w_n;
      if (preset_en) begin
        tm_hour <= preset_hour;
        tm_min  <= preset_min;
      end else if (tick_en) begin
        tm_hour <= (tm_hour == 8'd23) ? 8'd0 : tm_hour + 8'd1;
      end
      if (!tm_wn_d && w_n && !w_en_n) begin
        if (addr == 16'h0000) tm_min <= t;
        else if (addr == 16'h0001) tm_hour <= t;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_t;
    rst_n = 1'b0; req = 2'b00; req2 = 2'b00;
    req_hour0 = 8'd0; req_hour1 = 8'd0; req_min0 = 8'd0; req_min1 = 8'd0;
    preset_en = 1'b0; tick_en = 1'b0; preset_hour = 8'd0; preset_min = 8'd0;
    repeat (3) step();

    // Reset values
    @(negedge clock);
    check("rst_ack", ack, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_w_n", w_n, 1'b1);
    check("rst_w_en_n", w_en_n, 1'b1);
    check("rst_t", t, 8'd0);
    check("rst_addr", addr, 16'd0);
    check("rst2_w_n", w_n2, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // Port 0 writes 13:45
    req = 2'b01; req_hour0 = 8'd13; req_min0 = 8'd45;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      check($sformatf("v_w_n_c%0d", c), w_n, (c == 1 || c == 2 || c == 5 || c == 6) ? 1'b0 : 1'b1);
      check($sformatf("v_w_en_n_c%0d", c), w_en_n, (c >= 1 && c <= 8) ? 1'b0 : 1'b1);
      check($sformatf("v_ack_c%0d", c), ack, (c == 9) ? 2'b01 : 2'b00);
      if (c >= 1 && c <= 4) begin
        check($sformatf("v_addr_c%0d", c), addr, 16'h0000);
        check($sformatf("v_t_c%0d", c), t, 8'd45);
      end
      if (c >= 5 && c <= 8) begin
        check($sformatf("v_addr_c%0d", c), addr, 16'h0001);
        check($sformatf("v_t_c%0d", c), t, 8'd13);
      end
      if (c == 9) check("v_err", err, 1'b0);
      if (c == 10) check("v_busy_idle", busy, 1'b0);
      step();
      if (c == 9) req = 2'b00;
    end
    check("v_tm_hour", tm_hour, 8'd13);
    check("v_tm_min", tm_min, 8'd45);

    // Port 1 requests 24:00, rejected
    req = 2'b10; req_hour1 = 8'd24; req_min1 = 8'd0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clock);
      check($sformatf("inv_w_n_c%0d", c), w_n, 1'b1);
      check($sformatf("inv_w_en_n_c%0d", c), w_en_n, 1'b1);
      check($sformatf("inv_ack_c%0d", c), ack, (c == 1) ? 2'b10 : 2'b00);
      check($sformatf("inv_err_c%0d", c), err, (c == 1) ? 1'b1 : 1'b0);
      if (c == 2) check("inv_busy_c2", busy, 1'b0);
      step();
      if (c == 1) req = 2'b00;
    end
    check("inv_tm_hour", tm_hour, 8'd13);

    // Both ports together from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req = 2'b11; req_hour0 = 8'd1; req_min0 = 8'd2; req_hour1 = 8'd3; req_min1 = 8'd4;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock);
      check($sformatf("both_ack_c%0d", c), ack, (c == 9) ? 2'b01 : (c == 19) ? 2'b10 : 2'b00);
      if (c == 5) check("both_t_c5", t, 8'd1);
      if (c == 10) check("both_busy_c10", busy, 1'b0);
      if (c == 11) check("both_busy_c11", busy, 1'b1);
      if (c == 11) check("both_t_c11", t, 8'd4);
      if (c == 15) check("both_t_c15", t, 8'd3);
      step();
      if (c == 9) req[0] = 1'b0;
      if (c == 19) req[1] = 1'b0;
    end
    check("both_tm_hour", tm_hour, 8'd3);
    check("both_tm_min", tm_min, 8'd4);

    // PULSE_LEN=1, HOLD=3 instance
    req2 = 2'b01; req_hour0 = 8'd20; req_min0 = 8'd33;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      check($sformatf("p1_w_n_c%0d", c), w_n2, (c == 1 || c == 5) ? 1'b0 : 1'b1);
      check($sformatf("p1_ack_c%0d", c), ack2, (c == 9) ? 2'b01 : 2'b00);
      if (c >= 1 && c <= 8) begin
        exp_t = (c <= 4) ? 8'd33 : 8'd20;
        check($sformatf("p1_t_c%0d", c), t2, exp_t);
        check($sformatf("p1_addr_c%0d", c), addr2, (c <= 4) ? 16'h0000 : 16'h0001);
      end
      step();
      if (c == 9) req2 = 2'b00;
    end

    // Reset asserted during HR_LO
    req = 2'b01; req_hour0 = 8'd5; req_min0 = 8'd6;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      if (c == 5) begin
        check("rm_hrlo_w_n", w_n, 1'b0);
        check("rm_hrlo_addr", addr, 16'h0001);
        rst_n = 1'b0;
      end
      if (c < 5) step();
    end
    step();
    req = 2'b00;
    @(negedge clock);
    check("rm_ack", ack, 2'b00);
    check("rm_err", err, 1'b0);
    check("rm_busy", busy, 1'b0);
    check("rm_w_n", w_n, 1'b1);
    check("rm_w_en_n", w_en_n, 1'b1);
    check("rm_t", t, 8'd0);
    check("rm_addr", addr, 16'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clock);
      check($sformatf("rm_noack_%0d", c), ack, 2'b00);
    end
    step();
    rst_n = 1'b1;
    step();
    req = 2'b01; req_hour0 = 8'd9; req_min0 = 8'd30;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      check($sformatf("ra_ack_c%0d", c), ack, (c == 9) ? 2'b01 : 2'b00);
      step();
      if (c == 9) req = 2'b00;
    end
    check("ra_tm_hour", tm_hour, 8'd9);
    check("ra_tm_min", tm_min, 8'd30);

    // Hour carry from the timer lands between the minute and hour writes
    preset_en = 1'b1; preset_hour = 8'd10; preset_min = 8'd59;
    step();
    preset_en = 1'b0;
    req = 2'b01; req_hour0 = 8'd7; req_min0 = 8'd59;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      if (c == 5) begin
        check("tick_mid_hour", tm_hour, 8'd11);
        check("tick_mid_min", tm_min, 8'd59);
      end
      step();
      tick_en = (c == 3);
      if (c == 9) req = 2'b00;
    end
    check("tick_final_hour", tm_hour, 8'd7);
    check("tick_final_min", tm_min, 8'd59);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
